imem_server: RTL and testbench

//  Instruction-memory responder at the far end of the fetch interface. Accepts
//  one fetch request (PC) at a time over a valid/ready handshake and returns the
//  32-bit instruction word after LATENCY cycles, held until the fetch side takes it.

---
 rtl/imem_server.sv | 169 ++++++++++++++++
 tb/tb_imem_server.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_server.sv
`timescale 1ns/1ps
// imem_server: instruction-memory responder for the fetch path.
// Takes one PC at a time over a valid/ready handshake. It returns the
// 32-bit word a fixed number of cycles later. The word is held until the
// fetch side consumes it. A 1 KiB window at BASE_ADDR is decoded.
// Misaligned or out-of-window PCs produce an error response that carries
// ERR_INST. A side port preloads the program image.
module imem_server #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_3000,  // low 10 bits must be zero
  parameter int          DEPTH_LOG2 = 8,              // 256 words = 1 KiB
  parameter int          LATENCY    = 2,              // legal range 1..15
  parameter logic [31:0] ERR_INST   = 32'h0000_0000   // nop on error
) (
  input  logic                  clk,
  input  logic                  reset_n,
  // fetch request
  input  logic                  req_valid,
  input  logic [31:0]           req_addr,
  output logic                  req_ready,
  // fetch response
  output logic                  rsp_valid,
  output logic [31:0]           rsp_inst,
  output logic                  rsp_err,
  input  logic                  rsp_ready,
  // PC redirect
  input  logic                  flush,
  // program preload
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [31:0]           ld_data
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [31:0] r_rsp_inst;
  logic        r_rsp_err;
  logic [31:0] r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_misaligned;
  logic                  w_out_window;
  logic                  w_out_depth;
  logic                  w_err;
  logic [31:0]           w_word_idx;
  logic [DEPTH_LOG2-1:0] w_mem_idx;

  // ---------------------------------------------------------------------
  // Handshake and address decode
  // ---------------------------------------------------------------------
  // Ready only while idle. A flush cycle blocks acceptance. Reset forces
  // ready low even though the state is already IDLE.
  assign req_ready = (r_state == S_IDLE) && !flush && reset_n;
  assign w_accept  = req_valid && req_ready;

  // The word offset inside the 1 KiB window is always 8 bits. Only the
  // low DEPTH_LOG2 bits of it address the array.
  assign w_word_idx   = {24'd0, req_addr[9:2]};
  assign w_mem_idx    = req_addr[DEPTH_LOG2+1:2];
  assign w_misaligned = (req_addr[1:0] != 2'b00);
  assign w_out_window = (req_addr[31:10] != BASE_ADDR[31:10]);
  assign w_out_depth  = (w_word_idx >= 32'(DEPTH));
  assign w_err        = w_misaligned || w_out_window || w_out_depth;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  // State register and latency counter.
  // NOTE: sequential state is updated with <= so that every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic. Flush overrides everything. WAIT counts down to zero.
  // RESP leaves only on a consume handshake.
  // NOTE: both outputs get a default first, so no path leaves them
  // unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = 4'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (LATENCY == 1) begin
              w_state_nxt = S_RESP;
            end else begin
              w_state_nxt = S_WAIT;
              w_cnt_nxt   = 4'(LATENCY - 2);
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            w_state_nxt = S_RESP;
          end else begin
            w_cnt_nxt = r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Response data
  // ---------------------------------------------------------------------
  // Capture the word at the accept edge. The stored value then stays
  // frozen through WAIT and RESP, whatever later preload writes happen.
  // Flush clears the response payload.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_inst <= 32'd0;
      r_rsp_err  <= 1'b0;
    end else if (flush) begin
      r_rsp_inst <= 32'd0;
      r_rsp_err  <= 1'b0;
    end else if (w_accept) begin
      r_rsp_inst <= w_err ? ERR_INST : r_mem[w_mem_idx];
      r_rsp_err  <= w_err;
    end
  end

  assign rsp_valid = (r_state == S_RESP);
  assign rsp_inst  = r_rsp_inst;
  assign rsp_err   = r_rsp_err;

  // ---------------------------------------------------------------------
  // Program memory
  // ---------------------------------------------------------------------
  // Preload write port, open in every state. It is gated off while reset
  // is held. The read on the accept edge sees the old contents, because
  // this write lands at the same edge.
  // NOTE: the array has no reset, so it maps onto plain RAM and the
  // preloaded program survives a reset pulse.
  always_ff @(posedge clk) begin
    if (ld_en && reset_n) begin
      r_mem[ld_addr] <= ld_data;
    end
  end

endmodule

// File: tb/tb_imem_server.sv
`timescale 1ns/1ps
// Testbench for imem_server.
// Two instances share the clock, reset and preload port: one uses
// LATENCY=2 and one uses LATENCY=1. Expected responses come from a
// word-array model of the 1 KiB window.
module tb_imem_server;

  localparam logic [31:0] BASE     = 32'h0000_3000;
  localparam logic [31:0] ERR_INST = 32'h0000_0000;
  localparam int          LAT0     = 2;
  localparam int          LAT1     = 1;

  logic        clk;
  logic        reset_n;
  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;

  logic        req_valid [2];
  logic [31:0] req_addr  [2];
  logic        rsp_ready [2];
  logic        flush     [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_inst  [2];
  logic        rsp_err   [2];

  logic [31:0] model_mem [256];
  int          exp_lat   [2];
  int          n_checks;
  int          n_fail;

  imem_server #(.BASE_ADDR(BASE), .DEPTH_LOG2(8), .LATENCY(LAT0), .ERR_INST(ERR_INST)) u_dut0 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid[0]), .req_addr(req_addr[0]), .req_ready(req_ready[0]),
    .rsp_valid(rsp_valid[0]), .rsp_inst(rsp_inst[0]), .rsp_err(rsp_err[0]),
    .rsp_ready(rsp_ready[0]), .flush(flush[0]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  imem_server #(.BASE_ADDR(BASE), .DEPTH_LOG2(8), .LATENCY(LAT1), .ERR_INST(ERR_INST)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid[1]), .req_addr(req_addr[1]), .req_ready(req_ready[1]),
    .rsp_valid(rsp_valid[1]), .rsp_inst(rsp_inst[1]), .rsp_err(rsp_err[1]),
    .rsp_ready(rsp_ready[1]), .flush(flush[1]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic model_err(input logic [31:0] a);
    return ((a % 4) != 0) || ((a / 1024) != (BASE / 1024)) || (((a % 1024) / 4) >= 256);
  endfunction

  function automatic logic [31:0] model_inst(input logic [31:0] a);
    return model_err(a) ? ERR_INST : model_mem[(a % 1024) / 4];
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int idx, input logic [31:0] val);
    ld_en   = 1'b1;
    ld_addr = 8'(idx);
    ld_data = val;
    tick();
    ld_en = 1'b0;
    model_mem[idx] = val;
  endtask

  // One full transaction on instance d. The caller may request a preload
  // write to the same word on the accept edge. It may also ask for the
  // response to be held back for `hold` cycles. During that hold the
  // word is rewritten, which must not disturb the response in flight.
  task automatic do_fetch(input int d, input logic [31:0] a, input int hold,
                          input bit same_ld, input logic [31:0] same_val);
    logic [31:0] e_inst;
    logic        e_err;
    logic [31:0] held;
    int          idx;
    int          lat;
    e_inst = model_inst(a);
    e_err  = model_err(a);
    idx    = int'((a % 1024) / 4);
    check("req_ready_idle", 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_addr[d]  = a;
    rsp_ready[d] = 1'b0;
    if (same_ld) begin
      ld_en   = 1'b1;
      ld_addr = 8'(idx);
      ld_data = same_val;
    end
    tick();
    req_valid[d] = 1'b0;
    ld_en        = 1'b0;
    if (same_ld) model_mem[idx] = same_val;
    lat = 1;
    while (!rsp_valid[d] && lat <= 20) begin
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat[d]));
    check("rsp_valid", 32'(rsp_valid[d]), 32'd1);
    check("rsp_inst", rsp_inst[d], e_inst);
    check("rsp_err", 32'(rsp_err[d]), 32'(e_err));
    check("req_ready_busy", 32'(req_ready[d]), 32'd0);
    for (int h = 0; h < hold; h++) begin
      if (h == 0) begin
        held    = $urandom;
        ld_en   = 1'b1;
        ld_addr = 8'(idx);
        ld_data = held;
      end
      tick();
      if (h == 0) begin
        ld_en = 1'b0;
        model_mem[idx] = held;
      end
      check("hold_valid", 32'(rsp_valid[d]), 32'd1);
      check("hold_inst", rsp_inst[d], e_inst);
      check("hold_err", 32'(rsp_err[d]), 32'(e_err));
      check("hold_ready", 32'(req_ready[d]), 32'd0);
    end
    rsp_ready[d] = 1'b1;
    tick();
    rsp_ready[d] = 1'b0;
    check("post_valid", 32'(rsp_valid[d]), 32'd0);
    check("post_ready", 32'(req_ready[d]), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    logic [31:0] v;
    int          d;
    int          r;
    n_checks   = 0;
    n_fail     = 0;
    exp_lat[0] = LAT0;
    exp_lat[1] = LAT1;
    ld_en      = 1'b0;
    ld_addr    = 8'd0;
    ld_data    = 32'd0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b1;
      req_addr[i]  = BASE;
      rsp_ready[i] = 1'b0;
      flush[i]     = 1'b0;
    end

    // 1: reset with a request pending.
    reset_n = 1'b0;
    #23;
    for (int i = 0; i < 2; i++) begin
      check("rst_req_ready", 32'(req_ready[i]), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
      check("rst_rsp_inst", rsp_inst[i], 32'd0);
      check("rst_rsp_err", 32'(rsp_err[i]), 32'd0);
    end
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    check("rel_req_ready0", 32'(req_ready[0]), 32'd1);
    check("rel_req_ready1", 32'(req_ready[1]), 32'd1);

    // Fill the whole window so that the model and the RAM agree.
    for (int i = 0; i < 256; i++) load(i, $urandom);

    // 2: basic fetch.
    load(0, 32'h3C01_1234);
    do_fetch(0, 32'h0000_3000, 0, 1'b0, 32'd0);

    // 3: back-pressure for 5 cycles.
    do_fetch(0, 32'h0000_3014, 5, 1'b0, 32'd0);

    // 4: error cases and the last word.
    do_fetch(0, 32'h0000_3002, 0, 1'b0, 32'd0);
    do_fetch(0, 32'h0000_4000, 0, 1'b0, 32'd0);
    load(255, 32'h1234_5678);
    do_fetch(0, 32'h0000_33FC, 0, 1'b0, 32'd0);

    // 5: flush during WAIT.
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h0000_3004;
    tick();
    req_valid[0] = 1'b0;
    flush[0]     = 1'b1;
    #1;
    check("flush_blocks_ready", 32'(req_ready[0]), 32'd0);
    tick();
    flush[0] = 1'b0;
    check("flush_inst_cleared", rsp_inst[0], 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("flush_no_rsp", 32'(rsp_valid[0]), 32'd0);
      tick();
    end
    do_fetch(0, 32'h0000_3008, 0, 1'b0, 32'd0);

    // Flush together with rsp_ready while in RESP: the response is dropped.
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h0000_300C;
    tick();
    req_valid[0] = 1'b0;
    tick();
    check("pre_flush_valid", 32'(rsp_valid[0]), 32'd1);
    flush[0]     = 1'b1;
    rsp_ready[0] = 1'b1;
    tick();
    flush[0]     = 1'b0;
    rsp_ready[0] = 1'b0;
    check("flush_resp_valid", 32'(rsp_valid[0]), 32'd0);
    check("flush_resp_inst", rsp_inst[0], 32'd0);

    // Flush in IDLE with req_valid high: nothing is accepted.
    req_valid[1] = 1'b1;
    req_addr[1]  = 32'h0000_3000;
    flush[1]     = 1'b1;
    #1;
    check("idle_flush_ready", 32'(req_ready[1]), 32'd0);
    tick();
    req_valid[1] = 1'b0;
    flush[1]     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("idle_flush_no_rsp", 32'(rsp_valid[1]), 32'd0);
      tick();
    end

    // 6: same-edge preload on both latencies.
    load(4, 32'h0BAD_F00D);
    do_fetch(0, 32'h0000_3010, 0, 1'b1, 32'hDEAD_BEEF);
    do_fetch(0, 32'h0000_3010, 0, 1'b0, 32'd0);
    load(4, 32'h5555_AAAA);
    do_fetch(1, 32'h0000_3010, 0, 1'b1, 32'hCAFE_F00D);
    do_fetch(1, 32'h0000_3010, 2, 1'b0, 32'd0);

    // Reset mid-operation: outputs drop at once. A preload attempted
    // during reset is ignored. The memory keeps its contents.
    load(7, 32'h7777_0007);
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h0000_3000;
    req_valid[1] = 1'b1;
    req_addr[1]  = 32'h0000_301C;
    tick();
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    check("pre_rst_valid1", 32'(rsp_valid[1]), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid0", 32'(rsp_valid[0]), 32'd0);
    check("mid_rst_valid1", 32'(rsp_valid[1]), 32'd0);
    check("mid_rst_inst1", rsp_inst[1], 32'd0);
    ld_en   = 1'b1;
    ld_addr = 8'd7;
    ld_data = 32'hFFFF_FFFF;
    tick();
    tick();
    ld_en   = 1'b0;
    reset_n = 1'b1;
    #1;
    do_fetch(0, 32'h0000_3000, 0, 1'b0, 32'd0);
    do_fetch(1, 32'h0000_301C, 0, 1'b0, 32'd0);

    // Randomized transactions against the model.
    for (int n = 0; n < 200; n++) begin
      d = int'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      if (r < 7)       a = BASE + 32'($urandom_range(0, 255)) * 4;
      else if (r == 7) a = BASE + 32'($urandom_range(0, 1023)) | 32'd1;
      else if (r == 8) a = $urandom & 32'hFFFF_FFFC;
      else             a = BASE + 32'h400 + 32'($urandom_range(0, 255)) * 4;
      if ($urandom_range(0, 7) == 0) load(int'($urandom_range(0, 255)), $urandom);
      v = $urandom;
      do_fetch(d, a, int'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0), v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
